// File: rtl/emsx_tone_mixer.sv
// emsx_tone_mixer: two square tones plus a shared sawtooth, mixed per channel with
// saturation and noise-shaped onto two 6-bit DAC codes; also stretches reset for neighbours.
// Latency: mix registers on the sample tick, DAC codes one clock later; no backpressure (free-running).
module emsx_tone_mixer #(
  parameter int unsigned CLK_DIV     = 486,
  parameter int unsigned POR_CYCLES  = 1024,
  parameter int unsigned TONE_L_HALF = 50,
  parameter int unsigned TONE_R_HALF = 25,
  parameter logic [15:0] AMP         = 16'd4096,
  parameter logic [15:0] SAW_STEP    = 16'd256
) (
  input  logic       clk21m,
  input  logic       reset,
  output logic       power_on_reset,
  output logic [5:0] pDac_SL,
  output logic [5:0] pDac_SR
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int POR_W = $clog2(POR_CYCLES + 1);
  localparam int HL_W  = (TONE_L_HALF > 1) ? $clog2(TONE_L_HALF) : 1;
  localparam int HR_W  = (TONE_R_HALF > 1) ? $clog2(TONE_R_HALF) : 1;
  localparam logic [15:0] AMP_NEG = 16'd0 - AMP;

  logic             r_por;
  logic [POR_W-1:0] r_por_cnt;
  logic [DIV_W-1:0] r_div;
  logic [HL_W-1:0]  r_cnt_a, w_cnt_a_nxt;
  logic [HR_W-1:0]  r_cnt_b, w_cnt_b_nxt;
  logic             r_neg_a, w_neg_a_nxt;
  logic             r_neg_b, w_neg_b_nxt;
  logic [15:0]      r_saw, w_saw_nxt;
  logic [15:0]      r_mix_l, r_mix_r;
  logic [9:0]       r_err_l, r_err_r;
  logic [5:0]       r_dac_l, r_dac_r;

  logic             w_arst;
  logic             w_tick;
  logic [15:0]      w_sq_a, w_sq_b, w_saw_half;
  logic [16:0]      w_sum_l, w_sum_r;
  logic [15:0]      w_q_l, w_q_r;

  // Clamp a 17-bit signed sum into the 16-bit signed range.
  function automatic logic [15:0] sat17(input logic [16:0] s);
    if (s[16] != s[15]) sat17 = s[16] ? 16'h8000 : 16'h7FFF;
    else                sat17 = s[15:0];
  endfunction

  // First-order error feedback quantizer; returns {code, new error}.
  // The top-of-range case pins the error so a full-scale input cannot wrap the code.
  function automatic logic [15:0] quant(input logic [15:0] u, input logic [9:0] err);
    logic [16:0] s;
    s = {1'b0, u} + {7'd0, err};
    if (s[16]) quant = {6'd63, 10'h3FF};
    else       quant = s[15:0];
  endfunction

  // Audio path stays parked while either reset or the stretched POR is active.
  assign w_arst = reset | r_por;
  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  // Stretch reset: hold power_on_reset for POR_CYCLES clocks after reset drops.
  always_ff @(posedge clk21m) begin
    if (reset) begin
      r_por     <= 1'b1;
      r_por_cnt <= '0;
    end else if (r_por) begin
      if (r_por_cnt == POR_W'(POR_CYCLES - 1)) r_por <= 1'b0;
      else                                     r_por_cnt <= r_por_cnt + POR_W'(1);
    end
  end

  // Sample-rate divider producing a one-clock tick at its terminal count.
  always_ff @(posedge clk21m) begin
    if (w_arst || w_tick) r_div <= '0;
    else                  r_div <= r_div + DIV_W'(1);
  end

  // Next state of the tone generators; they only move on a tick.
  always_comb begin
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_neg_a_nxt = r_neg_a;
    w_neg_b_nxt = r_neg_b;
    w_saw_nxt   = r_saw;
    if (w_tick) begin
      if (r_cnt_a == HL_W'(TONE_L_HALF - 1)) begin
        w_cnt_a_nxt = '0;
        w_neg_a_nxt = ~r_neg_a;
      end else begin
        w_cnt_a_nxt = r_cnt_a + HL_W'(1);
      end
      if (r_cnt_b == HR_W'(TONE_R_HALF - 1)) begin
        w_cnt_b_nxt = '0;
        w_neg_b_nxt = ~r_neg_b;
      end else begin
        w_cnt_b_nxt = r_cnt_b + HR_W'(1);
      end
      w_saw_nxt = r_saw + SAW_STEP;
    end
  end

  // Tone generator state registers; phase 0 is the + half of the square.
  always_ff @(posedge clk21m) begin
    if (w_arst) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_saw   <= '0;
    end else begin
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_neg_a <= w_neg_a_nxt;
      r_neg_b <= w_neg_b_nxt;
      r_saw   <= w_saw_nxt;
    end
  end

  // The mix samples the post-tick tone values so a phase flip is heard on its own tick.
  assign w_sq_a     = w_neg_a_nxt ? AMP_NEG : AMP;
  assign w_sq_b     = w_neg_b_nxt ? AMP_NEG : AMP;
  assign w_saw_half = {w_saw_nxt[15], w_saw_nxt[15:1]};
  assign w_sum_l    = {w_sq_a[15], w_sq_a} + {w_saw_half[15], w_saw_half};
  assign w_sum_r    = {w_sq_b[15], w_sq_b} + {w_saw_half[15], w_saw_half};

  // Saturated per-channel mix, held between ticks.
  always_ff @(posedge clk21m) begin
    if (w_arst) begin
      r_mix_l <= '0;
      r_mix_r <= '0;
    end else if (w_tick) begin
      r_mix_l <= sat17(w_sum_l);
      r_mix_r <= sat17(w_sum_r);
    end
  end

  // Offset binary (flip the sign bit) then quantize against the carried error.
  assign w_q_l = quant(r_mix_l ^ 16'h8000, r_err_l);
  assign w_q_r = quant(r_mix_r ^ 16'h8000, r_err_r);

  // DAC code and error registers, updated every clock for noise shaping.
  always_ff @(posedge clk21m) begin
    if (w_arst) begin
      r_dac_l <= 6'd32;
      r_dac_r <= 6'd32;
      r_err_l <= '0;
      r_err_r <= '0;
    end else begin
      r_dac_l <= w_q_l[15:10];
      r_err_l <= w_q_l[9:0];
      r_dac_r <= w_q_r[15:10];
      r_err_r <= w_q_r[9:0];
    end
  end

  assign power_on_reset = r_por;
  assign pDac_SL        = r_dac_l;
  assign pDac_SR        = r_dac_r;

endmodule

// File: tb/tb_emsx_tone_mixer.sv
// Directed bench for emsx_tone_mixer: four instances with different parameter sets
// share one clock and reset; t counts falling edges since the first reset release.
module tb_emsx_tone_mixer;

  logic clk;
  logic reset;
  int   t;
  int   n_tests;
  int   n_fail;

  logic       dut_por, saw_por, sat_por, dc_por;
  logic [5:0] dut_sl, dut_sr, saw_sl, saw_sr, sat_sl, sat_sr, dc_sl, dc_sr;

  emsx_tone_mixer #(.CLK_DIV(4), .POR_CYCLES(8), .AMP(16'd4096), .SAW_STEP(16'd0)) u_dut (
    .clk21m(clk), .reset(reset), .power_on_reset(dut_por), .pDac_SL(dut_sl), .pDac_SR(dut_sr));

  emsx_tone_mixer #(.CLK_DIV(4), .POR_CYCLES(8), .AMP(16'd0), .SAW_STEP(16'd4096)) u_saw (
    .clk21m(clk), .reset(reset), .power_on_reset(saw_por), .pDac_SL(saw_sl), .pDac_SR(saw_sr));

  emsx_tone_mixer #(.CLK_DIV(4), .POR_CYCLES(8), .TONE_L_HALF(1), .AMP(16'd32767),
                    .SAW_STEP(16'd32768)) u_sat (
    .clk21m(clk), .reset(reset), .power_on_reset(sat_por), .pDac_SL(sat_sl), .pDac_SR(sat_sr));

  emsx_tone_mixer #(.AMP(16'd1536), .SAW_STEP(16'd0)) u_dc (
    .clk21m(clk), .reset(reset), .power_on_reset(dc_por), .pDac_SL(dc_sl), .pDac_SR(dc_sr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_to(input int target);
    while (t < target) step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(10);
    n_tests++; if (dut_por !== 1'b1) begin n_fail++; $display("FAIL reset_por: got %0d want 1", dut_por); end
    n_tests++; if (dut_sl !== 6'd32) begin n_fail++; $display("FAIL reset_sl: got %0d want 32", dut_sl); end
    n_tests++; if (dut_sr !== 6'd32) begin n_fail++; $display("FAIL reset_sr: got %0d want 32", dut_sr); end
    n_tests++; if (dc_por !== 1'b1) begin n_fail++; $display("FAIL reset_dc_por: got %0d want 1", dc_por); end
  endtask

  task automatic test_por_release();
    reset = 1'b0;
    t = 0;
    wait_to(7);
    n_tests++; if (dut_por !== 1'b1) begin n_fail++; $display("FAIL por_hold: got %0d want 1 at t=7", dut_por); end
    n_tests++; if (dut_sl !== 6'd32) begin n_fail++; $display("FAIL por_sl_held: got %0d want 32", dut_sl); end
    wait_to(8);
    n_tests++; if (dut_por !== 1'b0) begin n_fail++; $display("FAIL por_drop: got %0d want 0 at t=8", dut_por); end
  endtask

  task automatic test_saturation();
    int         tt [7] = '{13, 14, 17, 20, 21, 25, 28};
    logic [5:0] el [7] = '{6'd0, 6'd0, 6'd63, 6'd63, 6'd0, 6'd63, 6'd63};
    for (int i = 0; i < 7; i++) begin
      wait_to(tt[i]);
      n_tests++;
      if (sat_sl !== el[i]) begin
        n_fail++; $display("FAIL sat_left t=%0d: got %0d want %0d", t, sat_sl, el[i]);
      end
      if (t == 13) begin
        n_tests++; if (sat_sr !== 6'd47) begin n_fail++; $display("FAIL sat_right_t13: got %0d want 47", sat_sr); end
      end
      if (t == 14) begin
        n_tests++; if (sat_sr !== 6'd48) begin n_fail++; $display("FAIL sat_right_t14: got %0d want 48", sat_sr); end
      end
      if (t == 17) begin
        n_tests++; if (sat_sr !== 6'd63) begin n_fail++; $display("FAIL sat_right_t17: got %0d want 63", sat_sr); end
      end
    end
  endtask

  task automatic test_saw();
    int         tt [5] = '{37, 41, 69, 73, 77};
    logic [5:0] el [5] = '{6'd46, 6'd16, 6'd30, 6'd32, 6'd34};
    for (int i = 0; i < 5; i++) begin
      wait_to(tt[i]);
      n_tests++;
      if (saw_sl !== el[i]) begin
        n_fail++; $display("FAIL saw t=%0d: got %0d want %0d", t, saw_sl, el[i]);
      end
    end
  endtask

  task automatic test_tones();
    int         tt [9] = '{100, 108, 109, 208, 209, 308, 309, 408, 409};
    logic [5:0] el [9] = '{6'd36, 6'd36, 6'd36, 6'd36, 6'd28, 6'd28, 6'd28, 6'd28, 6'd36};
    logic [5:0] er [9] = '{6'd36, 6'd36, 6'd28, 6'd28, 6'd36, 6'd36, 6'd28, 6'd28, 6'd36};
    for (int i = 0; i < 9; i++) begin
      wait_to(tt[i]);
      n_tests++;
      if (dut_sl !== el[i]) begin
        n_fail++; $display("FAIL tone_left t=%0d: got %0d want %0d", t, dut_sl, el[i]);
      end
      n_tests++;
      if (dut_sr !== er[i]) begin
        n_fail++; $display("FAIL tone_right t=%0d: got %0d want %0d", t, dut_sr, er[i]);
      end
    end
  endtask

  task automatic test_dc();
    int sum_l = 0;
    int sum_r = 0;
    wait_to(1023);
    n_tests++; if (dc_por !== 1'b1) begin n_fail++; $display("FAIL dc_por_hold: got %0d want 1", dc_por); end
    wait_to(1024);
    n_tests++; if (dc_por !== 1'b0) begin n_fail++; $display("FAIL dc_por_drop: got %0d want 0", dc_por); end
    wait_to(1510);
    n_tests++; if (dc_sl !== 6'd32) begin n_fail++; $display("FAIL dc_before_tick: got %0d want 32", dc_sl); end
    wait_to(1511);
    n_tests++; if (dc_sl !== 6'd33) begin n_fail++; $display("FAIL dc_first: got %0d want 33", dc_sl); end
    wait_to(1512);
    n_tests++; if (dc_sl !== 6'd34) begin n_fail++; $display("FAIL dc_second: got %0d want 34", dc_sl); end
    wait_to(1599);
    for (int i = 0; i < 1024; i++) begin
      step(1);
      sum_l += int'(dc_sl);
      sum_r += int'(dc_sr);
    end
    n_tests++; if (sum_l != 34304) begin n_fail++; $display("FAIL dc_mean_left: sum %0d want 34304", sum_l); end
    n_tests++; if (sum_r != 34304) begin n_fail++; $display("FAIL dc_mean_right: sum %0d want 34304", sum_r); end
  endtask

  task automatic test_reset_mid_tone();
    wait_to(2650);
    n_tests++; if (dut_sl !== 6'd28) begin n_fail++; $display("FAIL mid_pre_left: got %0d want 28", dut_sl); end
    reset = 1'b1;
    step(1);
    n_tests++; if (dut_sl !== 6'd32) begin n_fail++; $display("FAIL mid_rst_left: got %0d want 32", dut_sl); end
    n_tests++; if (dut_sr !== 6'd32) begin n_fail++; $display("FAIL mid_rst_right: got %0d want 32", dut_sr); end
    n_tests++; if (dut_por !== 1'b1) begin n_fail++; $display("FAIL mid_rst_por: got %0d want 1", dut_por); end
    reset = 1'b0;
    wait_to(2658);
    n_tests++; if (dut_por !== 1'b1) begin n_fail++; $display("FAIL mid_por_hold: got %0d want 1", dut_por); end
    wait_to(2659);
    n_tests++; if (dut_por !== 1'b0) begin n_fail++; $display("FAIL mid_por_drop: got %0d want 0", dut_por); end
    wait_to(2663);
    n_tests++; if (dut_sl !== 6'd32) begin n_fail++; $display("FAIL mid_pre_tick: got %0d want 32", dut_sl); end
    wait_to(2664);
    n_tests++; if (dut_sl !== 6'd36) begin n_fail++; $display("FAIL mid_restart_left: got %0d want 36", dut_sl); end
    n_tests++; if (dut_sr !== 6'd36) begin n_fail++; $display("FAIL mid_restart_right: got %0d want 36", dut_sr); end
    n_tests++; if (saw_sl !== 6'd34) begin n_fail++; $display("FAIL mid_restart_saw: got %0d want 34", saw_sl); end
  endtask

  task automatic test_por_restart();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(5);
    n_tests++; if (dut_por !== 1'b1) begin n_fail++; $display("FAIL restart_first: got %0d want 1", dut_por); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(7);
    n_tests++; if (dut_por !== 1'b1) begin n_fail++; $display("FAIL restart_hold: got %0d want 1", dut_por); end
    step(1);
    n_tests++; if (dut_por !== 1'b0) begin n_fail++; $display("FAIL restart_drop: got %0d want 0", dut_por); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    t       = 0;
    test_reset();
    test_por_release();
    test_saturation();
    test_saw();
    test_tones();
    test_dc();
    test_reset_mid_tone();
    test_por_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
